// File: rtl/pulse_burst_ctrl.sv
// Burst sequencer for the LFSR pulse generator: programs the x_low/x_high
// thresholds, lets them settle, forwards N pulses, waits a hold-off, reports done.
module pulse_burst_ctrl #(
  parameter int P_CNT_W     = 32,
  parameter int P_HOLDOFF_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            cfg_x_low,
  input  logic [31:0]            cfg_x_high,
  input  logic [P_CNT_W-1:0]     cfg_burst_len,
  input  logic [P_HOLDOFF_W-1:0] cfg_holdoff,
  input  logic                   start,
  input  logic                   abort,
  output logic [31:0]            pg_x_low,
  output logic                   pg_x_low_wr,
  output logic [31:0]            pg_x_high,
  output logic                   pg_x_high_wr,
  input  logic                   pg_pulse_in,
  output logic                   pulse_out,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   cfg_err,
  output logic [P_CNT_W-1:0]     pulse_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOAD_LO, LOAD_HI, SETTLE_A, SETTLE_B, RUN, HOLDOFF, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            x_high_q, x_high_d;
  logic [P_CNT_W-1:0]     burst_q, burst_d;
  logic [P_HOLDOFF_W-1:0] holdoff_q, holdoff_d;
  logic [P_HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [31:0]            pg_x_low_d, pg_x_high_d;
  logic                   pg_x_low_wr_d, pg_x_high_wr_d;
  logic                   pulse_out_d, busy_d, done_d, aborted_d, cfg_err_d;
  logic [P_CNT_W-1:0]     pulse_cnt_d, cnt_inc, cnt_sat;

  // Every output is a flop fed by the next-state logic below, so strobes and
  // pulse_out line up with the state the sequencer is entering.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d        = state_q;
    x_high_d       = x_high_q;
    burst_d        = burst_q;
    holdoff_d      = holdoff_q;
    hold_cnt_d     = hold_cnt_q;
    pg_x_low_d     = pg_x_low;
    pg_x_high_d    = pg_x_high;
    pg_x_low_wr_d  = 1'b0;
    pg_x_high_wr_d = 1'b0;
    pulse_out_d    = 1'b0;
    done_d         = 1'b0;
    aborted_d      = 1'b0;
    cfg_err_d      = 1'b0;
    pulse_cnt_d    = pulse_cnt;
    cnt_inc        = pulse_cnt + P_CNT_W'(1);
    cnt_sat        = (&pulse_cnt) ? pulse_cnt : cnt_inc;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_x_low > cfg_x_high) begin
            cfg_err_d = 1'b1;
          end else begin
            x_high_d      = cfg_x_high;
            burst_d       = cfg_burst_len;
            holdoff_d     = cfg_holdoff;
            pulse_cnt_d   = '0;
            pg_x_low_d    = cfg_x_low;
            pg_x_low_wr_d = 1'b1;
            state_d       = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        pg_x_high_d    = x_high_q;
        pg_x_high_wr_d = 1'b1;
        state_d        = LOAD_HI;
      end
      LOAD_HI:  state_d = SETTLE_A;
      SETTLE_A: state_d = SETTLE_B;
      SETTLE_B: state_d = RUN;
      RUN: begin
        if (pg_pulse_in) begin
          pulse_out_d = 1'b1;
          pulse_cnt_d = cnt_sat;
          // A zero burst length never terminates; only abort leaves RUN.
          if (burst_q != '0 && cnt_inc == burst_q) begin
            hold_cnt_d = holdoff_q;
            state_d    = (holdoff_q == '0) ? DONE : HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q <= P_HOLDOFF_W'(1)) state_d = DONE;
        else hold_cnt_d = hold_cnt_q - P_HOLDOFF_W'(1);
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything except a strobe already on the outputs.
    if (abort && state_q != IDLE) begin
      state_d        = IDLE;
      hold_cnt_d     = hold_cnt_q;
      pg_x_high_d    = pg_x_high;
      pg_x_high_wr_d = 1'b0;
      pulse_out_d    = 1'b0;
      pulse_cnt_d    = pulse_cnt;
      done_d         = 1'b0;
      aborted_d      = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      x_high_q     <= '0;
      burst_q      <= '0;
      holdoff_q    <= '0;
      hold_cnt_q   <= '0;
      pg_x_low     <= '0;
      pg_x_low_wr  <= 1'b0;
      pg_x_high    <= '0;
      pg_x_high_wr <= 1'b0;
      pulse_out    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
      pulse_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      x_high_q     <= x_high_d;
      burst_q      <= burst_d;
      holdoff_q    <= holdoff_d;
      hold_cnt_q   <= hold_cnt_d;
      pg_x_low     <= pg_x_low_d;
      pg_x_low_wr  <= pg_x_low_wr_d;
      pg_x_high    <= pg_x_high_d;
      pg_x_high_wr <= pg_x_high_wr_d;
      pulse_out    <= pulse_out_d;
      busy         <= busy_d;
      done         <= done_d;
      aborted      <= aborted_d;
      cfg_err      <= cfg_err_d;
      pulse_cnt    <= pulse_cnt_d;
    end
  end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Scenario bench for pulse_burst_ctrl: forwarded pulses are scoreboarded,
// strobes and counters are compared inline in each scenario task.
module tb_pulse_burst_ctrl;

  logic        clk, rst;
  logic [31:0] cfg_x_low, cfg_x_high;
  logic [31:0] cfg_burst_len;
  logic [15:0] cfg_holdoff;
  logic        start, abort, pg_pulse_in;
  logic [31:0] pg_x_low, pg_x_high, pulse_cnt;
  logic        pg_x_low_wr, pg_x_high_wr, pulse_out, busy, done, aborted, cfg_err;

  // Narrow-counter instance used only for the saturation scenario.
  logic        start_s, abort_s;
  logic [3:0]  cfg_burst_len_s, s_pulse_cnt;
  logic [31:0] s_pg_x_low, s_pg_x_high;
  logic        s_x_low_wr, s_x_high_wr, s_pulse_out, s_busy, s_done, s_aborted, s_cfg_err;

  pulse_burst_ctrl dut (
    .clk(clk), .rst(rst), .cfg_x_low(cfg_x_low), .cfg_x_high(cfg_x_high),
    .cfg_burst_len(cfg_burst_len), .cfg_holdoff(cfg_holdoff),
    .start(start), .abort(abort),
    .pg_x_low(pg_x_low), .pg_x_low_wr(pg_x_low_wr),
    .pg_x_high(pg_x_high), .pg_x_high_wr(pg_x_high_wr),
    .pg_pulse_in(pg_pulse_in), .pulse_out(pulse_out), .busy(busy), .done(done),
    .aborted(aborted), .cfg_err(cfg_err), .pulse_cnt(pulse_cnt)
  );

  pulse_burst_ctrl #(.P_CNT_W(4), .P_HOLDOFF_W(16)) dut_sat (
    .clk(clk), .rst(rst), .cfg_x_low(cfg_x_low), .cfg_x_high(cfg_x_high),
    .cfg_burst_len(cfg_burst_len_s), .cfg_holdoff(cfg_holdoff),
    .start(start_s), .abort(abort_s),
    .pg_x_low(s_pg_x_low), .pg_x_low_wr(s_x_low_wr),
    .pg_x_high(s_pg_x_high), .pg_x_high_wr(s_x_high_wr),
    .pg_pulse_in(pg_pulse_in), .pulse_out(s_pulse_out), .busy(s_busy), .done(s_done),
    .aborted(s_aborted), .cfg_err(s_cfg_err), .pulse_cnt(s_pulse_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int due;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cycle;
  int   tests_run;
  int   tests_failed;

  // One clock; outputs are sampled on the falling edge, then the scoreboard
  // retires any pulse due this cycle and flags any pulse nobody expected.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (exp_q.size() != 0 && exp_q[0].due == cycle) begin
      e = exp_q.pop_front();
      tests_run++;
      if (pulse_out !== 1'b1 || pulse_cnt !== 32'(e.cnt)) begin
        tests_failed++;
        $display("FAIL sb_pulse cycle %0d: pulse_out=%0b pulse_cnt=%0d, expected 1 / %0d",
                 cycle, pulse_out, pulse_cnt, e.cnt);
      end
    end else if (pulse_out !== 1'b0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_unexpected_pulse cycle %0d: pulse_out=%0b, expected 0", cycle, pulse_out);
    end
  endtask

  // Start a burst and check both threshold writes; returns in the second
  // settle cycle, one edge before RUN.
  task automatic program_burst(input logic [31:0] lo, input logic [31:0] hi,
                               input int len, input int hold);
    cfg_x_low = lo; cfg_x_high = hi; cfg_burst_len = 32'(len); cfg_holdoff = 16'(hold);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (pg_x_low_wr !== 1'b1 || pg_x_low !== lo || pg_x_high_wr !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_lo: wr=%0b data=%h hi_wr=%0b busy=%0b, expected 1 %h 0 1",
               pg_x_low_wr, pg_x_low, pg_x_high_wr, busy, lo);
    end
    tick();
    tests_run++;
    if (pg_x_high_wr !== 1'b1 || pg_x_high !== hi || pg_x_low_wr !== 1'b0 || pg_x_low !== lo) begin
      tests_failed++;
      $display("FAIL load_hi: wr=%0b data=%h lo_wr=%0b lo=%h, expected 1 %h 0 %h",
               pg_x_high_wr, pg_x_high, pg_x_low_wr, pg_x_low, hi, lo);
    end
    tick();
    tick();
    tests_run++;
    if (pg_x_low_wr !== 1'b0 || pg_x_high_wr !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL settle: lo_wr=%0b hi_wr=%0b busy=%0b, expected 0 0 1",
               pg_x_low_wr, pg_x_high_wr, busy);
    end
  endtask

  // Drive pulses every `period` cycles in RUN and expect completion timing.
  task automatic run_burst(input int len, input int hold, input int period);
    int accepted, exp_done;
    bit done_seen, prev_busy;
    accepted = 0; exp_done = -1; done_seen = 0; prev_busy = 1'b1;
    tick();
    for (int k = 0; k < 200 && !done_seen; k++) begin
      pg_pulse_in = (k % period == 0);
      if (pg_pulse_in && accepted < len) begin
        accepted++;
        exp_q.push_back('{due: cycle + 1, cnt: accepted});
        if (accepted == len) exp_done = cycle + 1 + hold + 1;
      end
      prev_busy = busy;
      tick();
      if (done === 1'b1) begin
        done_seen = 1;
        tests_run++;
        if (cycle != exp_done || busy !== 1'b0 || prev_busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL done_timing: cycle=%0d busy=%0b prev_busy=%0b, expected cycle %0d busy 0 prev 1",
                   cycle, busy, prev_busy, exp_done);
        end
      end
    end
    pg_pulse_in = 1'b0;
    tests_run++;
    if (!done_seen || pulse_cnt !== 32'(len) || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL burst_end: done_seen=%0b pulse_cnt=%0d pending=%0d, expected 1 %0d 0",
               done_seen, pulse_cnt, exp_q.size(), len);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || aborted !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_one_cycle: done=%0b busy=%0b aborted=%0b, expected 0 0 0",
               done, busy, aborted);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({pg_x_low_wr, pg_x_high_wr, pulse_out, busy, done, aborted, cfg_err} !== 7'b0 ||
        pg_x_low !== 32'h0 || pg_x_high !== 32'h0 || pulse_cnt !== 32'h0 || s_pulse_cnt !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset: lo=%h hi=%h cnt=%0d busy=%0b done=%0b, expected all zero",
               pg_x_low, pg_x_high, pulse_cnt, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    program_burst(32'h1000, 32'h2000, 3, 5);
    run_burst(3, 5, 4);
  endtask

  task automatic test_settle_discard();
    pg_pulse_in = 1'b1;
    program_burst(32'h0040, 32'h0080, 2, 0);
    run_burst(2, 0, 1);
  endtask

  task automatic test_cfg_err();
    cfg_x_low = 32'd5; cfg_x_high = 32'd4; cfg_burst_len = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || pg_x_low_wr !== 1'b0 || pulse_cnt !== 32'd2) begin
      tests_failed++;
      $display("FAIL cfg_err: err=%0b busy=%0b wr=%0b cnt=%0d, expected 1 0 0 2",
               cfg_err, busy, pg_x_low_wr, pulse_cnt);
    end
    tick();
    tests_run++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || pg_x_high_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL cfg_err_one_cycle: err=%0b busy=%0b hi_wr=%0b, expected 0 0 0",
               cfg_err, busy, pg_x_high_wr);
    end
    // start and abort together: abort wins and nothing happens.
    cfg_x_low = 32'd1; cfg_x_high = 32'd9;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || pg_x_low_wr !== 1'b0 || aborted !== 1'b0 || cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_abort_same: busy=%0b wr=%0b aborted=%0b err=%0b, expected 0 0 0 0",
               busy, pg_x_low_wr, aborted, cfg_err);
    end
  endtask

  task automatic test_abort();
    int accepted;
    program_burst(32'h0010, 32'h0020, 10, 0);
    tick();
    accepted = 0;
    for (int k = 0; k < 40 && accepted < 4; k++) begin
      pg_pulse_in = (k % 2 == 0);
      if (pg_pulse_in) begin
        accepted++;
        exp_q.push_back('{due: cycle + 1, cnt: accepted});
      end
      if (k == 3) begin
        cfg_x_low = 32'h0777; cfg_x_high = 32'h0888; cfg_burst_len = 32'd3;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (k == 3) begin
        tests_run++;
        if (pg_x_low_wr !== 1'b0 || pg_x_low !== 32'h0010 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL start_while_busy: wr=%0b lo=%h busy=%0b, expected 0 00000010 1",
                   pg_x_low_wr, pg_x_low, busy);
        end
      end
    end
    abort = 1'b1; pg_pulse_in = 1'b1;
    tick();
    abort = 1'b0; pg_pulse_in = 1'b0;
    tests_run++;
    if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pulse_cnt !== 32'd4) begin
      tests_failed++;
      $display("FAIL abort_run: aborted=%0b busy=%0b done=%0b cnt=%0d, expected 1 0 0 4",
               aborted, busy, done, pulse_cnt);
    end
    tick();
    tests_run++;
    if (aborted !== 1'b0 || done !== 1'b0 || pulse_cnt !== 32'd4) begin
      tests_failed++;
      $display("FAIL abort_one_cycle: aborted=%0b done=%0b cnt=%0d, expected 0 0 4",
               aborted, done, pulse_cnt);
    end
    // Abort in LOAD_LO: the visible x_low strobe stays, no x_high write follows.
    cfg_x_low = 32'h0100; cfg_x_high = 32'h0200; cfg_burst_len = 32'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (pg_x_low_wr !== 1'b1 || pg_x_low !== 32'h0100) begin
      tests_failed++;
      $display("FAIL abort_load_inflight: wr=%0b lo=%h, expected 1 00000100", pg_x_low_wr, pg_x_low);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (aborted !== 1'b1 || pg_x_high_wr !== 1'b0 || busy !== 1'b0 || pulse_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL abort_load: aborted=%0b hi_wr=%0b busy=%0b cnt=%0d, expected 1 0 0 0",
               aborted, pg_x_high_wr, busy, pulse_cnt);
    end
    tick();
  endtask

  task automatic test_saturate();
    cfg_x_low = 32'h1; cfg_x_high = 32'h2; cfg_burst_len_s = 4'd0; cfg_holdoff = 16'd0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int k = 0; k < 20; k++) begin
      pg_pulse_in = 1'b1;
      tick();
      tests_run++;
      if (s_pulse_cnt !== ((k + 1 > 15) ? 4'hF : 4'(k + 1)) || s_busy !== 1'b1 || s_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL saturate step %0d: cnt=%0d busy=%0b done=%0b, expected %0d 1 0",
                 k, s_pulse_cnt, s_busy, s_done, (k + 1 > 15) ? 15 : k + 1);
      end
    end
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0; pg_pulse_in = 1'b0;
    tests_run++;
    if (s_aborted !== 1'b1 || s_busy !== 1'b0 || s_pulse_cnt !== 4'hF) begin
      tests_failed++;
      $display("FAIL saturate_abort: aborted=%0b busy=%0b cnt=%0d, expected 1 0 15",
               s_aborted, s_busy, s_pulse_cnt);
    end
    tick();
  endtask

  task automatic test_reset_in_holdoff();
    program_burst(32'h0300, 32'h0400, 1, 8);
    tick();
    pg_pulse_in = 1'b1;
    exp_q.push_back('{due: cycle + 1, cnt: 1});
    tick();
    pg_pulse_in = 1'b0;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL holdoff_busy: busy=%0b done=%0b, expected 1 0", busy, done);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({pg_x_low_wr, pg_x_high_wr, pulse_out, busy, done, aborted, cfg_err} !== 7'b0 ||
        pg_x_low !== 32'h0 || pg_x_high !== 32'h0 || pulse_cnt !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_holdoff: lo=%h hi=%h cnt=%0d busy=%0b done=%0b aborted=%0b, expected all zero",
               pg_x_low, pg_x_high, pulse_cnt, busy, done, aborted);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_quiet %0d: done=%0b aborted=%0b busy=%0b, expected 0 0 0",
                 i, done, aborted, busy);
      end
    end
    test_basic();
  endtask

  initial begin
    cycle = 0; tests_run = 0; tests_failed = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pg_pulse_in = 1'b0;
    cfg_x_low = '0; cfg_x_high = '0; cfg_burst_len = '0; cfg_holdoff = '0;
    start_s = 1'b0; abort_s = 1'b0; cfg_burst_len_s = '0;
    test_reset();
    test_basic();
    test_settle_discard();
    test_cfg_err();
    test_abort();
    test_saturate();
    test_reset_in_holdoff();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pulse_burst_ctrl.md
Name: pulse_burst_ctrl

Overview:
Sequencer for the LFSR-driven pulse generator. On a start request it latches a threshold window and a burst length. It programs the generator's x_low/x_high registers through their write strobes and waits for them to settle. It then forwards exactly N generator pulses to pulse_out, observes a programmable hold-off, and reports done. It sits between the command/response controller, which drives the configuration and start/abort inputs, and the pulse generator datapath.

Parameters:
P_CNT_W, 32, width of burst length and pulse counter
P_HOLDOFF_W, 16, width of hold-off cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_x_low  in  32  lower threshold for generator, sampled on accepted start
cfg_x_high  in  32  upper threshold, sampled on accepted start
cfg_burst_len  in  P_CNT_W  pulses per burst; 0 = free-run until abort
cfg_holdoff  in  P_HOLDOFF_W  post-burst dead cycles
start  in  1  single-cycle start request
abort  in  1  single-cycle abort request
pg_x_low  out  32  threshold data to generator
pg_x_low_wr  out  1  x_low write strobe
pg_x_high  out  32  threshold data to generator
pg_x_high_wr  out  1  x_high write strobe
pg_pulse_in  in  1  raw generator pulse
pulse_out  out  1  gated, registered pulse
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion strobe
aborted  out  1  one-cycle abort strobe
cfg_err  out  1  one-cycle strobe: start rejected, x_low > x_high
pulse_cnt  out  P_CNT_W  pulses forwarded in current/last burst

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all outputs 0; internal cfg registers 0.
- All outputs registered. Strobes are high for exactly one cycle.
- IDLE:
  - start=1, abort=0, cfg_x_low<=cfg_x_high (unsigned): latch all cfg_* inputs, clear pulse_cnt, go to LOAD_LO.
  - start=1 with cfg_x_low>cfg_x_high: cfg_err=1 next cycle, stay IDLE, pulse_cnt unchanged.
  - start and abort in the same cycle: abort wins, no effect, no strobe.
- LOAD_LO: pg_x_low=latched low, pg_x_low_wr=1 for one cycle, then go to LOAD_HI.
- LOAD_HI: pg_x_high=latched high, pg_x_high_wr=1 for one cycle, then go to SETTLE.
- pg_x_low/pg_x_high hold their last written value at all other times.
- SETTLE: 2 cycles, then RUN. Generator pulses are ignored here (old-threshold pulses discarded).
- RUN:
  - pulse_out(t+1) = pg_pulse_in(t). Each accepted pulse increments pulse_cnt.
  - When the accepted pulse makes pulse_cnt == burst_len, go to HOLDOFF, or to DONE if holdoff==0. No further pulses are forwarded.
  - burst_len==0: remain in RUN indefinitely; pulse_cnt saturates at all-ones and does not wrap.
- HOLDOFF: pulses blocked; count down exactly cfg_holdoff cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls the same cycle done rises.
- Latency from start to first cycle in RUN: 4 cycles (LOAD_LO, LOAD_HI, 2×SETTLE).
- start while busy: ignored, latched cfg unchanged.
- abort in any non-IDLE state:
  - Next state IDLE; aborted=1 one cycle; done not asserted.
  - pulse_cnt holds its value.
  - A pulse arriving on the abort cycle is not forwarded.
  - abort in LOAD_LO/LOAD_HI does not suppress that cycle's in-flight write strobe.
- abort in IDLE: no effect.
- pulse_out is 0 in every state except the cycle following an accepted RUN pulse.
- rst mid-burst: immediate return to IDLE per reset values; no done or aborted strobe.

Test Plan:
1. x_low=0x1000, x_high=0x2000, burst_len=3, holdoff=5, start; pg_pulse_in high every 4th cycle -> wr strobes at cycles +1,+2 with correct data; exactly 3 pulse_out, each 1 cycle after its input; done 5 cycles after the 3rd accepted pulse is processed; pulse_cnt=3.
2. Pulses held high during SETTLE and continuously in RUN with burst_len=2, holdoff=0 -> no forwarding in SETTLE; pulse_out high exactly 2 cycles; done on the following cycle.
3. x_low=5, x_high=4, start -> cfg_err=1 for one cycle; busy stays 0; no wr strobes.
4. burst_len=10; abort after 4 pulses -> aborted=1, no done, pulse_cnt=4, busy=0 next cycle; second start during the burst is ignored.
5. burst_len=0, pulse_cnt preloaded near all-ones (force or short P_CNT_W=4 build), continuous pulses -> pulse_cnt saturates at 0xF; state stays RUN until abort.
6. rst asserted during HOLDOFF -> all outputs 0 next cycle; no done; a new start then behaves as in test 1.
